uart_byte_ctrl: RTL and testbench
=================================

# uart_byte_ctrl

Byte-level UART engine serving the core's SENDB/RECVB instructions. Accepts a one-cycle command from the main control decoder (send a byte or receive a byte), serialises or deserialises it on 8N1 lines, and returns a single-cycle completion pulse that releases the decoder's busy-wait state. Sits between the control/datapath and the board's UART pins.

## Interface
- CLK_PER_BIT, 868: clk cycles per bit, ≥ 4; 868 is 115200 baud at 100 MHz.
- RX_FIFO_DEPTH, 8: receive FIFO entries, power of two; used only with UART_RX_FIFO_EN.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- uart_go  in  1  command strobe, sampled only in IDLE.
- rors  in  1  command type at uart_go: 1 = send, 0 = receive.
- tx_data  in  8  byte to send, latched at command accept.
- rx_data  out  8  last received byte; reset 0; changes only in the uart_done cycle of a receive.
- uart_done  out  1  one-cycle completion pulse; reset 0.
- rx_overflow  out  1  sticky, FIFO overrun; reset 0; tied 0 without UART_RX_FIFO_EN.
- txd  out  1  serial out; reset 1 (idle mark).
- rxd  in  1  serial in, asynchronous.

## Operation
- Command FSM: IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, DONE.
- IDLE + uart_go + rors=1: latch tx_data, → TX_START. IDLE + uart_go + rors=0: → RX_WAIT. uart_go outside IDLE ignored (no queueing).
- TX: start bit 0, 8 data bits LSB first, stop bit 1; each bit held CLK_PER_BIT cycles via bit-period counter; 3-bit bit index. TX_STOP end → DONE.
- DONE: uart_done=1 for one cycle, → IDLE.
- RX deserialiser: rxd through 2-flop synchroniser. HUNT: falling edge → counter; at CLK_PER_BIT/2 (integer division) re-sample; 1 = glitch → HUNT. Then 8 data samples every CLK_PER_BIT, LSB first, then stop sample. Stop=0: framing error, byte discarded, → HUNT, no completion. Stop=1: byte valid (one-cycle internal strobe), → HUNT.
- Without FIFO: deserialiser enabled only in RX_WAIT; valid byte → rx_data, → DONE. Bytes arriving outside RX_WAIT lost. Deserialiser forced to HUNT on leaving RX_WAIT.
- TX and RX share one command FSM; no full-duplex commands.

## Timing
- Send accepted cycle t: txd=0 from t+1; bit k (k=0..7) starts t+1+(k+1)·CLK_PER_BIT; stop bit t+1+9·CLK_PER_BIT; uart_done at t+1+10·CLK_PER_BIT.
- Receive without FIFO: uart_done and new rx_data one cycle after the valid stop sample.
- Receive with FIFO, non-empty: uart_done and rx_data at t+1 (pop at t+1). Empty: pop/done one cycle after the push strobe; push and pop never the same entry in one cycle.
- Reset mid-frame: txd→1, FSM→IDLE, deserialiser→HUNT, FIFO emptied, rx_overflow cleared, all in the next edge.

## Configuration
- UART_RX_FIFO_EN defined: deserialiser always enabled, independent of commands; valid bytes pushed to RX_FIFO_DEPTH-entry FIFO; push when full drops new byte and sets rx_overflow (cleared only by reset); receive command pops oldest.
- Undefined: no FIFO, behaviour per "Without FIFO" above, rx_overflow=0.

## Structure
- Package uart_pkg: FSM state enum, RX state enum, default CLK_PER_BIT, UART_CMD_SEND=1'b1 / UART_CMD_RECV=1'b0 constants (shared with control decoder).
- Sub-module uart_rx: synchroniser + deserialiser, outputs byte + valid strobe + enable input. FIFO inline in top under the macro.

## Test plan
- CLK_PER_BIT=4, send 8'hA5 at t=10 → txd 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit from t=11; uart_done only at t=51.
- Receive, drive 8'h3C frame on rxd after command → rx_data=8'h3C with one uart_done pulse; no pulse before stop bit.
- Frame with stop=0 then valid 8'h81 → first discarded, uart_done once, rx_data=8'h81.
- 1-cycle low glitch on rxd in HUNT → no reception, rx_data unchanged.
- With UART_RX_FIFO_EN, depth 8: 9 frames with no commands → rx_overflow=1; 8 receive commands return bytes 0..7 in order, each done at t+1.
- rstn low mid-transmit bit 3 → txd=1 next cycle, no uart_done, new send after reset completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the byte-level UART engine and the control decoder.
package uart_pkg;

    localparam int unsigned UART_CLK_PER_BIT_DEF = 868;

    localparam logic UART_CMD_SEND = 1'b1;
    localparam logic UART_CMD_RECV = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_START,
        ST_TX_DATA,
        ST_TX_STOP,
        ST_RX_WAIT,
        ST_DONE
    } uart_state_e;

    typedef enum logic [1:0] {
        RX_HUNT,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_e;

endpackage

// File: rtl/uart_byte_ctrl_if.sv
// Command/response bundle between the control decoder (master) and the UART engine (slave).
interface uart_byte_ctrl_if;
    logic       uart_go;
    logic       rors;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       uart_done;
    logic       rx_overflow;

    modport master (output uart_go, rors, tx_data, input  rx_data, uart_done, rx_overflow);
    modport slave  (input  uart_go, rors, tx_data, output rx_data, uart_done, rx_overflow);
endinterface

// File: rtl/uart_rx.sv
// 8N1 deserialiser: 2-flop synchroniser, mid-bit sampling, one-cycle valid strobe per good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_en,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_valid
);
    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam int unsigned HALF  = CLK_PER_BIT / 2;

    logic [1:0]       r_sync;
    logic             r_prev;
    uart_rx_state_e   r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_byte;
    logic             r_valid;
    logic             w_rxd;
    logic             w_bit_end;

    assign w_rxd     = r_sync[1];
    assign w_bit_end = (r_cnt == CNT_W'(CLK_PER_BIT - 1));
    assign o_byte    = r_byte;
    assign o_valid   = r_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= RX_HUNT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rxd};
            r_prev  <= w_rxd;
            r_valid <= 1'b0;
            if (!i_en) begin
                r_state <= RX_HUNT;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    RX_HUNT: begin
                        if (r_prev && !w_rxd) begin
                            r_state <= RX_START;
                            r_cnt   <= '0;
                        end
                    end
                    // half a bit after the detected edge: still low means a real start bit
                    RX_START: begin
                        if (r_cnt == CNT_W'(HALF - 1)) begin
                            r_cnt <= '0;
                            r_idx <= '0;
                            r_state <= w_rxd ? RX_HUNT : RX_DATA;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    RX_DATA: begin
                        if (w_bit_end) begin
                            r_cnt   <= '0;
                            r_shift <= {w_rxd, r_shift[7:1]};
                            r_idx   <= r_idx + 3'd1;
                            if (r_idx == 3'd7) r_state <= RX_STOP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    RX_STOP: begin
                        if (w_bit_end) begin
                            r_cnt   <= '0;
                            r_state <= RX_HUNT;
                            if (w_rxd) begin
                                r_byte  <= r_shift;
                                r_valid <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= RX_HUNT;
                endcase
            end
        end
    end
endmodule

// File: rtl/uart_byte_ctrl.sv
// Byte UART engine for SENDB/RECVB: one command at a time, single-cycle uart_done on completion.
// Optional receive FIFO selected with `define UART_RX_FIFO_EN.
module uart_byte_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT_DEF
`ifdef UART_RX_FIFO_EN
    , parameter int unsigned RX_FIFO_DEPTH = 8
`endif
) (
    input  logic             clk,
    input  logic             rstn,
    uart_byte_ctrl_if.slave  bus,
    output logic             txd,
    input  logic             rxd
);
    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);

    uart_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_tx_byte;
    logic             r_txd;
    logic             r_done;
    logic [7:0]       r_rx_data;
    logic [7:0]       w_rx_byte;
    logic             w_rx_valid;
    logic             w_rx_en;
    logic             w_bit_end;

    assign w_bit_end     = (r_cnt == CNT_W'(CLK_PER_BIT - 1));
    assign txd           = r_txd;
    assign bus.uart_done = r_done;
    assign bus.rx_data   = r_rx_data;

`ifdef UART_RX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(RX_FIFO_DEPTH);

    logic [7:0]     r_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W:0]   r_count;
    logic             r_ovf;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // a byte arriving while a receive waits goes straight to rx_data, bypassing the FIFO
    assign w_rx_en  = 1'b1;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (PTR_W + 1)'(RX_FIFO_DEPTH));
    assign w_pop    = (r_state == ST_IDLE) && bus.uart_go && (bus.rors == UART_CMD_RECV) && !w_empty;
    assign w_push   = w_rx_valid && (r_state != ST_RX_WAIT) && !w_full;
    assign w_drop   = w_rx_valid && (r_state != ST_RX_WAIT) && w_full;
    assign bus.rx_overflow = r_ovf;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_rx_byte;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PTR_W + 1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PTR_W + 1)'(1);
            if (w_drop) r_ovf <= 1'b1;
        end
    end
`else
    assign w_rx_en         = (r_state == ST_RX_WAIT);
    assign bus.rx_overflow = 1'b0;
`endif

    uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (w_rx_en),
        .i_rxd   (rxd),
        .o_byte  (w_rx_byte),
        .o_valid (w_rx_valid)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_tx_byte <= '0;
            r_txd     <= 1'b1;
            r_done    <= 1'b0;
            r_rx_data <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.uart_go) begin
                        if (bus.rors == UART_CMD_SEND) begin
                            r_tx_byte <= bus.tx_data;
                            r_txd     <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= ST_TX_START;
                        end
`ifdef UART_RX_FIFO_EN
                        else if (!w_empty) begin
                            r_rx_data <= r_mem[r_rd];
                            r_done    <= 1'b1;
                            r_state   <= ST_DONE;
                        end
`endif
                        else begin
                            r_state <= ST_RX_WAIT;
                        end
                    end
                end
                ST_TX_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_txd   <= r_tx_byte[0];
                        r_state <= ST_TX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_TX_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= ST_TX_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_txd <= r_tx_byte[r_idx + 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_TX_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RX_WAIT: begin
                    if (w_rx_valid) begin
                        r_rx_data <= w_rx_byte;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_byte_ctrl.sv
// Self-checking bench for uart_byte_ctrl with CLK_PER_BIT=4; FIFO section active when UART_RX_FIFO_EN is defined.
module tb_uart_byte_ctrl;
    import uart_pkg::*;

    localparam int CPB = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic rxd  = 1'b1;
    logic txd;

    uart_byte_ctrl_if bif();

    uart_byte_ctrl #(.CLK_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif.slave),
        .txd  (txd),
        .rxd  (rxd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state: expected line/flag values derived from frame timing rules
    bit         tx_act   = 1'b0;
    int         tx_t     = 0;
    logic [7:0] tx_b     = 8'h00;
    int         win_lo   = -1;
    int         win_hi   = -1;
    bit         win_rx   = 1'b0;
    logic [7:0] win_byte = 8'h00;
    logic [7:0] exp_rx   = 8'h00;
    bit         exp_ovf  = 1'b0;
    bit         ovf_known = 1'b1;
    bit         chk_en   = 1'b0;
    int         done_seen = 0;
    int         done_cyc  = -1;
    bit         in_win;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // txd expected from the send start time and byte: start, 8 data LSB first, stop
    function automatic logic m_txd(input int c);
        int o;
        int k;
        if (!tx_act) return 1'b1;
        o = c - tx_t - 1;
        if (o < 0) return 1'b1;
        k = o / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return tx_b[k-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("txd", {31'd0, txd}, {31'd0, m_txd(cyc)});
            if (ovf_known) check("rx_overflow", {31'd0, bif.rx_overflow}, {31'd0, exp_ovf});
            if (bif.uart_done) begin
                in_win = (win_lo >= 0) && (cyc >= win_lo) && (cyc <= win_hi);
                check("done_in_window", {31'd0, in_win}, 32'd1);
                if (in_win) begin
                    done_seen++;
                    done_cyc = cyc;
                    win_lo   = -1;
                    if (win_rx) exp_rx = win_byte;
                end
            end
            check("rx_data", {24'd0, bif.rx_data}, {24'd0, exp_rx});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stopb);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stopb;
        tick(CPB);
        rxd = 1'b1;
    endtask

    task automatic do_send(input logic [7:0] b, input bit poke);
        int t0;
        bif.uart_go = 1'b1;
        bif.rors    = UART_CMD_SEND;
        bif.tx_data = b;
        t0 = cyc;
        tx_act = 1'b1; tx_t = t0; tx_b = b;
        win_lo = t0 + 1 + 10*CPB; win_hi = win_lo; win_rx = 1'b0;
        done_seen = 0;
        tick();
        bif.uart_go = 1'b0;
        bif.tx_data = 8'($urandom);
        if (poke) begin
            tick($urandom_range(1, 30));
            bif.uart_go = 1'b1;
            bif.rors    = 1'($urandom);
            tick();
            bif.uart_go = 1'b0;
        end
        while (cyc <= t0 + 1 + 10*CPB) tick();
        check("tx_done_count", done_seen, 1);
    endtask

    // mode 0: clean frame, 1: framing-error frame first, 2: one-cycle glitch first
    task automatic do_recv(input logic [7:0] b, input int mode);
        int f;
        bif.uart_go = 1'b1;
        bif.rors    = UART_CMD_RECV;
        tick();
        bif.uart_go = 1'b0;
        tick($urandom_range(0, 3));
        done_seen = 0;
        if (mode == 1) begin
            drive_frame(8'($urandom), 1'b0);
            tick(2);
            check("bad_frame_no_done", done_seen, 0);
        end else if (mode == 2) begin
            rxd = 1'b0;
            tick();
            rxd = 1'b1;
            tick(4*CPB);
            check("glitch_no_done", done_seen, 0);
        end
        f = cyc;
        win_lo = f + 9*CPB; win_hi = f + 11*CPB; win_rx = 1'b1; win_byte = b;
        drive_frame(b, 1'b1);
        while (cyc <= f + 11*CPB) tick();
        check("rx_done_count", done_seen, 1);
        check("rx_data_final", {24'd0, bif.rx_data}, {24'd0, b});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_bits;
        int t0;
        bif.uart_go = 1'b0;
        bif.rors    = UART_CMD_RECV;
        bif.tx_data = 8'h00;
        tick(3);
        @(negedge clk);
        check("reset_txd",  {31'd0, txd}, 32'd1);
        check("reset_done", {31'd0, bif.uart_done}, 32'd0);
        check("reset_rx",   {24'd0, bif.rx_data}, 32'd0);
        check("reset_ovf",  {31'd0, bif.rx_overflow}, 32'd0);
        tick();
        rstn = 1'b1;
        tick(2);
        chk_en = 1'b1;

        // hand-computed 8'hA5 waveform, bit 0 transmitted first
        a5_bits = 10'b11_0100_1010;
        t0 = cyc;
        fork
            do_send(8'hA5, 1'b0);
            begin
                for (int i = 0; i < 10; i++) begin
                    while (cyc < t0 + 1 + i*CPB + 1) @(posedge clk);
                    @(negedge clk);
                    check("a5_bit", {31'd0, txd}, {31'd0, a5_bits[i]});
                end
            end
        join
        check("a5_done_offset", done_cyc - t0, 41);

        do_recv(8'h3C, 0);
        do_recv(8'h81, 1);
        do_recv(8'h5A, 2);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) do_send(8'($urandom), 1'($urandom));
            else                           do_recv(8'($urandom), int'($urandom_range(0, 2)));
            tick($urandom_range(0, 3));
        end

`ifdef UART_RX_FIFO_EN
        for (int k = 0; k < 9; k++) begin
            if (k == 8) ovf_known = 1'b0;
            drive_frame(8'(k), 1'b1);
            tick(3);
        end
        tick(4);
        exp_ovf   = 1'b1;
        ovf_known = 1'b1;
        check("fifo_ovf_set", {31'd0, bif.rx_overflow}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            int tp;
            tp = cyc;
            win_lo = tp + 1; win_hi = tp + 1; win_rx = 1'b1; win_byte = 8'(k);
            done_seen = 0;
            bif.uart_go = 1'b1;
            bif.rors    = UART_CMD_RECV;
            tick();
            bif.uart_go = 1'b0;
            tick();
            check("fifo_pop_done", done_seen, 1);
            check("fifo_pop_data", {24'd0, bif.rx_data}, k);
        end
`endif

        // reset during data bit 3 of a send
        bif.uart_go = 1'b1;
        bif.rors    = UART_CMD_SEND;
        bif.tx_data = 8'h5A;
        t0 = cyc;
        tx_act = 1'b1; tx_t = t0; tx_b = 8'h5A;
        win_lo = t0 + 1 + 10*CPB; win_hi = win_lo; win_rx = 1'b0;
        done_seen = 0;
        tick();
        bif.uart_go = 1'b0;
        while (cyc < t0 + 1 + 4*CPB + 1) tick();
        rstn = 1'b0;
        tick();
        tx_act = 1'b0; win_lo = -1; exp_rx = 8'h00; exp_ovf = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check("txd_after_reset", {31'd0, txd}, 32'd1);
        tick(12*CPB);
        check("reset_no_done", done_seen, 0);
        do_send(8'hC3, 1'b0);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
